// File: rtl/urisc_mem_resp.sv
// urisc_mem_resp: 2^AW x DW memory responder for the URISC CSMR/WRITE/RDMR bus with one I/O port.
// Define URISC_MEM_CLEAR_EN to build the post-reset zero-fill sweep (BUSY high while it runs).
module urisc_mem_resp #(
   parameter int DW = 8,
   parameter int AW = 8,
   parameter logic [AW-1:0] IO_ADDR = 8'hFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          CS,
   input  logic          WRITE,
   input  logic          READ,
   input  logic [AW-1:0] ADDRESS,
   input  logic [DW-1:0] WDATA,
   output logic [DW-1:0] RDATA,
   output logic          BUSY,
   input  logic [DW-1:0] IO_IN,
   output logic [DW-1:0] IO_OUT
);

   logic [DW-1:0] mem [2**AW];

   logic [DW-1:0] rdata_q, rdata_d;
   logic [DW-1:0] io_out_q, io_out_d;
   logic          bus_en;
   logic          sweep_we;
   logic [AW-1:0] sweep_addr;
   logic          mem_we;
   logic [AW-1:0] mem_waddr;
   logic [DW-1:0] mem_wdata;
   logic          is_io;

`ifdef URISC_MEM_CLEAR_EN
   typedef enum logic [0:0] {CLEAR, IDLE} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic          busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      if (state_q == CLEAR) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == {AW{1'b1}}) begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

   assign bus_en     = rst_n && (state_q == IDLE);
   assign sweep_we   = rst_n && (state_q == CLEAR);
   assign sweep_addr = cnt_q;
   assign BUSY       = busy_q;
`else
   assign bus_en     = rst_n;
   assign sweep_we   = 1'b0;
   assign sweep_addr = '0;
   assign BUSY       = 1'b0;
`endif

   assign is_io = (ADDRESS == IO_ADDR);

   // The sweep owns the write port while it runs; bus accesses are gated off by bus_en.
   always_comb begin
      rdata_d   = rdata_q;
      io_out_d  = io_out_q;
      mem_we    = 1'b0;
      mem_waddr = ADDRESS;
      mem_wdata = WDATA;
      if (bus_en && CS) begin
         if (READ) begin
            rdata_d = is_io ? IO_IN : mem[ADDRESS];
         end
         if (WRITE) begin
            if (is_io) begin
               io_out_d = WDATA;
            end else begin
               mem_we = 1'b1;
            end
         end
      end
      if (sweep_we) begin
         mem_we    = 1'b1;
         mem_waddr = sweep_addr;
         mem_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rdata_q  <= '0;
         io_out_q <= '0;
      end else begin
         rdata_q  <= rdata_d;
         io_out_q <= io_out_d;
      end
   end

   assign RDATA  = rdata_q;
   assign IO_OUT = io_out_q;

endmodule

// File: tb/tb_urisc_mem_resp.sv
// Directed self-checking bench for urisc_mem_resp; expectations follow whether
// URISC_MEM_CLEAR_EN is defined for the build.
module tb_urisc_mem_resp;

`ifdef URISC_MEM_CLEAR_EN
   localparam bit ClearEn = 1'b1;
`else
   localparam bit ClearEn = 1'b0;
`endif

   logic       clock;
   logic       resetN;
   logic       csIn;
   logic       writeIn;
   logic       readIn;
   logic [7:0] addressIn;
   logic [7:0] wdataIn;
   logic [7:0] rdataOut;
   logic       busyOut;
   logic [7:0] ioIn;
   logic [7:0] ioOut;

   int checks;
   int errors;
   int busyCycles;
   int nonZero;

   urisc_mem_resp dut (
      .clk    (clock),
      .rst_n  (resetN),
      .CS     (csIn),
      .WRITE  (writeIn),
      .READ   (readIn),
      .ADDRESS(addressIn),
      .WDATA  (wdataIn),
      .RDATA  (rdataOut),
      .BUSY   (busyOut),
      .IO_IN  (ioIn),
      .IO_OUT (ioOut)
   );

   // Free-running clock, 10 time-unit period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Hard stop in case something stalls the directed sequence
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired before end of test");
      $fatal(1, "[TB] watchdog");
   end

   // Advance past one rising edge and settle so outputs can be sampled safely
   task automatic cycle();
      @(posedge clock);
      #1;
   endtask

   // Present one bus access for a single edge, then return the bus to idle
   task automatic applyStimulus(input logic cs, input logic wr, input logic rd,
                                input logic [7:0] addr, input logic [7:0] wdata);
      csIn      = cs;
      writeIn   = wr;
      readIn    = rd;
      addressIn = addr;
      wdataIn   = wdata;
      cycle();
      csIn      = 1'b0;
      writeIn   = 1'b0;
      readIn    = 1'b0;
   endtask

   // Compare an 8-bit observation against its hand-computed value
   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%02h expected=%02h", tag, observed, expected);
      end
   endtask

   // Compare an integer count against its hand-computed value
   task automatic checkCount(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Count edges until BUSY drops, bounded so a stuck BUSY still reaches the summary
   task automatic measureBusy(output int n);
      n = 0;
      while (busyOut && n < 400) begin
         cycle();
         n++;
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      resetN    = 1'b0;
      csIn      = 1'b0;
      writeIn   = 1'b0;
      readIn    = 1'b0;
      addressIn = 8'h00;
      wdataIn   = 8'h00;
      ioIn      = 8'h00;

      $display("[TB] start, clear sweep build = %0d", ClearEn);
      cycle();
      cycle();
      checkOutput("reset_rdata", rdataOut, 8'h00);
      checkOutput("reset_io_out", ioOut, 8'h00);
      checkOutput("reset_busy", {7'b0, busyOut}, {7'b0, ClearEn});
      resetN = 1'b1;

      // Write during the sweep must be dropped; without the sweep it lands
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, 8'hFF);
      measureBusy(busyCycles);
      busyCycles = busyCycles + 1;
      checkCount("busy_cycles", busyCycles, ClearEn ? 256 : 1);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
      checkOutput("write_while_busy", rdataOut, ClearEn ? 8'h00 : 8'hFF);

`ifdef URISC_MEM_CLEAR_EN
      nonZero = 0;
      for (int a = 0; a < 255; a++) begin
         applyStimulus(1'b1, 1'b0, 1'b1, a[7:0], 8'h00);
         if (rdataOut !== 8'h00) nonZero++;
      end
      checkCount("sweep_zero", nonZero, 0);
`endif

      applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
      checkOutput("read_after_write", rdataOut, 8'hA5);
      applyStimulus(1'b0, 1'b0, 1'b1, 8'h05, 8'h00);
      checkOutput("hold_cs_low", rdataOut, 8'hA5);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h05, 8'h00);
      checkOutput("hold_no_strobe", rdataOut, 8'hA5);

      applyStimulus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h3C);
      checkOutput("io_out_write", ioOut, 8'h3C);
      ioIn = 8'h5A;
      applyStimulus(1'b1, 1'b0, 1'b1, 8'hFF, 8'h00);
      checkOutput("io_in_read", rdataOut, 8'h5A);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
      checkOutput("mem_after_io", rdataOut, 8'hA5);

      applyStimulus(1'b1, 1'b1, 1'b0, 8'h20, 8'h11);
      applyStimulus(1'b1, 1'b1, 1'b1, 8'h20, 8'h22);
      checkOutput("rbw_old_data", rdataOut, 8'h11);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
      checkOutput("rbw_new_data", rdataOut, 8'h22);

      ioIn = 8'hC3;
      applyStimulus(1'b1, 1'b1, 1'b1, 8'hFF, 8'h99);
      checkOutput("io_rw_rdata", rdataOut, 8'hC3);
      checkOutput("io_rw_io_out", ioOut, 8'h99);

      applyStimulus(1'b1, 1'b1, 1'b0, 8'h40, 8'h01);
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h41, 8'h02);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h40, 8'h00);
      checkOutput("b2b_read_40", rdataOut, 8'h01);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h41, 8'h00);
      checkOutput("b2b_read_41", rdataOut, 8'h02);

      applyStimulus(1'b0, 1'b1, 1'b0, 8'h10, 8'hEE);
      applyStimulus(1'b0, 1'b1, 1'b0, 8'hFF, 8'hEE);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h10, 8'h00);
      checkOutput("cs_low_write_dropped", rdataOut, 8'hA5);
      checkOutput("cs_low_io_dropped", ioOut, 8'h99);

      // Reset in IDLE, then again partway into the (possible) sweep
      applyStimulus(1'b1, 1'b1, 1'b0, 8'h30, 8'h77);
      resetN = 1'b0;
      cycle();
      checkOutput("idle_reset_rdata", rdataOut, 8'h00);
      checkOutput("idle_reset_io_out", ioOut, 8'h00);
      checkOutput("idle_reset_busy", {7'b0, busyOut}, {7'b0, ClearEn});
      resetN = 1'b1;
      for (int i = 0; i < 100; i++) cycle();
      checkOutput("busy_at_count_100", {7'b0, busyOut}, {7'b0, ClearEn});
      resetN = 1'b0;
      cycle();
      resetN = 1'b1;
      measureBusy(busyCycles);
      checkCount("busy_after_mid_reset", busyCycles, ClearEn ? 256 : 0);
      applyStimulus(1'b1, 1'b0, 1'b1, 8'h30, 8'h00);
      checkOutput("data_across_reset", rdataOut, ClearEn ? 8'h00 : 8'h77);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
